wb_stage: RTL

Parametrised write-back stage for the pipelined MIPS core: it owns the MEM/WB pipeline register, selects register-file write data from a packed set of NSRC sources, and byte/half-extends load data. A one-entry buffered late-write port lets multi-cycle units such as the MDU or CP0 retire results without stalling the pipe. It sits between the MEM stage and the GRF write port, and also drives the forwarding value seen by the hazard unit.

---
 rtl/wb_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, source select with load extension, and a
// one-entry late-write buffer arbitrated onto the GRF port. Optional counter: WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int DW       = 32,
  parameter int NSRC     = 6,
  parameter int SELW     = 3,
  parameter int RAW      = 5,
  parameter int LOAD_SRC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_wb,
  input  logic               flush_wb,
  input  logic               valid_m,
  input  logic [NSRC*DW-1:0] src_m,
  input  logic [SELW-1:0]    sel_m,
  input  logic               regwrite_m,
  input  logic [RAW-1:0]     wa_m,
  input  logic [2:0]         ldtype_m,
  input  logic [1:0]         addr_lo_m,
  input  logic [DW-1:0]      pc_m,
  input  logic               late_valid,
  input  logic [RAW-1:0]     late_wa,
  input  logic [DW-1:0]      late_wd,
  output logic               late_ready,
  output logic               rf_we,
  output logic [RAW-1:0]     rf_wa,
  output logic [DW-1:0]      rf_wd,
  output logic [DW-1:0]      pc_wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);

  logic           wb_valid;
  logic           wb_regwrite;
  logic           wb_done;
  logic [RAW-1:0] wb_wa;
  logic [DW-1:0]  wb_data;
  logic [DW-1:0]  wb_pc;

  logic           late_full;
  logic [RAW-1:0] late_buf_wa;
  logic [DW-1:0]  late_buf_wd;

  logic [DW-1:0]  sel_data;
  logic [DW-1:0]  ext_data;
  logic [7:0]     byte_m;
  logic [15:0]    half_m;
  logic           pipe_wr;
  logic           late_drain;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_m == SELW'(i)) sel_data = src_m[i*DW +: DW];
    end
  end

  always_comb begin
    byte_m = sel_data[7:0];
    case (addr_lo_m)
      2'd1:    byte_m = sel_data[15:8];
      2'd2:    byte_m = sel_data[23:16];
      2'd3:    byte_m = sel_data[31:24];
      default: byte_m = sel_data[7:0];
    endcase
    half_m = addr_lo_m[1] ? sel_data[31:16] : sel_data[15:0];
    ext_data = sel_data;
    if (sel_m == SELW'(LOAD_SRC)) begin
      case (ldtype_m)
        3'd1:    ext_data = {{(DW-8){byte_m[7]}}, byte_m};
        3'd2:    ext_data = {{(DW-8){1'b0}}, byte_m};
        3'd3:    ext_data = {{(DW-16){half_m[15]}}, half_m};
        3'd4:    ext_data = {{(DW-16){1'b0}}, half_m};
        default: ext_data = sel_data;
      endcase
    end
  end

  // done marks an instruction that already had its WB cycle, so a stall
  // never writes or retires it twice.
  always_ff @(posedge clk) begin
    if (reset || flush_wb) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_done     <= 1'b0;
      wb_wa       <= '0;
      wb_data     <= '0;
      wb_pc       <= '0;
    end else if (stall_wb) begin
      wb_done     <= 1'b1;
    end else begin
      wb_valid    <= valid_m;
      wb_regwrite <= regwrite_m;
      wb_done     <= 1'b0;
      wb_wa       <= wa_m;
      wb_data     <= ext_data;
      wb_pc       <= pc_m;
    end
  end

  assign pipe_wr    = wb_valid & wb_regwrite & (wb_wa != '0) & ~wb_done;
  assign late_drain = ~pipe_wr & late_full;

  // Late port handshake: an entry transfers on an edge where late_valid and
  // late_ready are both high; late_ready depends only on buffer state.
  assign late_ready = ~late_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      late_full   <= 1'b0;
      late_buf_wa <= '0;
      late_buf_wd <= '0;
    end else if (late_drain) begin
      late_full   <= 1'b0;
    end else if (late_valid && !late_full) begin
      late_full   <= 1'b1;
      late_buf_wa <= late_wa;
      late_buf_wd <= late_wd;
    end
  end

  assign rf_we = pipe_wr | (late_drain & (late_buf_wa != '0));
  assign rf_wa = pipe_wr ? wb_wa   : (rf_we ? late_buf_wa : '0);
  assign rf_wd = pipe_wr ? wb_data : (rf_we ? late_buf_wd : '0);
  assign pc_wb = wb_pc;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (wb_valid && !wb_done) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
